uart_tx_serializer: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_serializer.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and baud divisor helper.
// Used by both the transmit serializer and the future receive-side blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Truncating divide: the line runs slightly fast rather than slow.
  function automatic int unsigned clks_per_bit(input int unsigned clock_rate,
                                               input int unsigned baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// restart holds the count at zero so the first period begins cleanly.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: valid/ready byte in, 8-bit async frame out on tx.
// All outputs are registered, so nothing combinational reaches the pins.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 24000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  // Handshake: a byte moves when in_valid && in_ready at a posedge. in_ready is
  // high only while idle and enabled, and drops on the accepting edge for the
  // whole frame, which the producer uses as its completion indication.

  localparam int unsigned CPB        = clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam logic [2:0]  LAST_STOP  = (STOP_BITS == 2) ? 3'd1 : 3'd0;
  localparam bit          HAS_PARITY = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);

  uart_state_e state, next_state;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [2:0]  bit_cnt;
  logic        tick;
  logic        accept;

  assign accept = in_valid && in_ready;

  uart_baud_tick #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == ST_IDLE),
    .tick    (tick)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_START;
      ST_START:  if (tick) next_state = ST_DATA;
      ST_DATA:   if (tick && bit_cnt == 3'd7) next_state = HAS_PARITY ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) next_state = ST_STOP;
      ST_STOP:   if (tick && bit_cnt == LAST_STOP) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      par_bit  <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == ST_IDLE) && enable;
      busy     <= (next_state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg   <= in_data;
            par_bit <= (PARITY == PARITY_ODD) ? ~^in_data : ^in_data;
            tx      <= 1'b0;
            bit_cnt <= 3'd0;
          end
        end
        ST_START: begin
          if (tick) begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              tx      <= HAS_PARITY ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx      <= 1'b1;
            bit_cnt <= 3'd0;
          end
        end
        ST_STOP: begin
          // bit_cnt counts stop bits here; tx is already high.
          if (tick) begin
            bit_cnt <= (bit_cnt == LAST_STOP) ? 3'd0 : bit_cnt + 3'd1;
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule
